tx_mac_control: RTL and testbench

TX_MAC_CONTROL -- requirements
Module: tx_mac_control

---
 rtl/tx_mac_control_pkg.sv | 36 +++
 rtl/tx_mac_control_if.sv | 29 ++
 rtl/tx_mac_control.sv | 199 +++++++++++++++++++
 tb/tb_tx_mac_control.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_mac_control_pkg.sv
// Shared constants, state encoding and CRC-32 helper for the GMII transmit MAC.
package tx_mac_control_pkg;

  localparam int          DATA_WIDTH      = 8;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_CONSTANT  = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam int          PREAMBLE_BYTES  = 8;
  localparam int          MIN_FRAME_BYTES = 60;
  localparam int          MAX_DATA_BYTES  = 1514;
  localparam int          IFG_BYTES       = 12;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    DROP,
    IFG
  } state_t;

  // Reflected Ethernet CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_mac_control_if.sv
// Frame-side handshake and GMII transmit bundle for tx_mac_control.
interface tx_mac_control_if;
  import tx_mac_control_pkg::*;

  logic [DATA_WIDTH-1:0] frame_data_i;
  logic                  frame_valid_i;
  logic                  frame_sof_i;
  logic                  frame_eof_i;
  logic                  frame_error_i;
  logic                  frame_ready_o;
  logic [DATA_WIDTH-1:0] gmii_tx_data_o;
  logic                  gmii_tx_en_o;
  logic                  gmii_tx_er_o;
  logic [31:0]           tx_frame_count_o;
  logic [31:0]           tx_abort_count_o;

  modport master (
    output frame_data_i, frame_valid_i, frame_sof_i, frame_eof_i, frame_error_i,
    input  frame_ready_o, gmii_tx_data_o, gmii_tx_en_o, gmii_tx_er_o,
           tx_frame_count_o, tx_abort_count_o
  );

  modport slave (
    input  frame_data_i, frame_valid_i, frame_sof_i, frame_eof_i, frame_error_i,
    output frame_ready_o, gmii_tx_data_o, gmii_tx_en_o, gmii_tx_er_o,
           tx_frame_count_o, tx_abort_count_o
  );

endinterface

// File: rtl/tx_mac_control.sv
// GMII transmit MAC: preamble/SFD insertion, padding to minimum size, FCS append,
// abort signalling and inter-frame gap, with registered GMII outputs.
//
// state    | meaning
// IDLE     | waiting for sof; non-sof bytes are drained and discarded
// PREAMBLE | emitting 0x55 bytes then the SFD
// DATA     | forwarding accepted payload bytes, checking for aborts
// PAD      | emitting 0x00 until the minimum frame length is reached
// FCS      | emitting the four CRC bytes, LSB first
// DROP     | discarding the rest of an aborted frame up to its eof
// IFG      | enforcing the inter-frame gap before returning to IDLE
module tx_mac_control
  import tx_mac_control_pkg::*;
(
  input  logic            switch_clk,
  input  logic            switch_rst_n,
  tx_mac_control_if.slave tx_if
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_DATA_BYTES);
  localparam logic [10:0] SAT_CNT  = 11'h7FF;
  localparam logic [3:0]  IFG_LOAD = 4'(IFG_BYTES - 1);
  localparam logic [2:0]  PRE_LOAD = 3'(PREAMBLE_BYTES - 2);

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [3:0]  ifg_cnt_q, ifg_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic        first_q, first_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        txer_q, txer_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] abort_cnt_q, abort_cnt_d;

  logic        valid, sof, eof;
  logic        ready_c;
  logic        data_abort;
  logic [10:0] cnt_inc;
  logic [31:0] fcs_word;

  assign valid    = tx_if.frame_valid_i;
  assign sof      = tx_if.frame_sof_i;
  assign eof      = tx_if.frame_eof_i;
  assign cnt_inc  = (byte_cnt_q == SAT_CNT) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign fcs_word = ~crc_q ^ {32{err_q}};

  assign data_abort = !valid || (sof && !first_q) || (cnt_inc > MAX_CNT);

  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      IDLE:       ready_c = valid && !sof;
      DATA, DROP: ready_c = 1'b1;
      default:    ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (valid && sof) state_d = PREAMBLE;
      PREAMBLE: if (pre_cnt_q == 3'd0) state_d = DATA;
      DATA: begin
        if (data_abort)  state_d = (valid && eof) ? IFG : DROP;
        else if (eof)    state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
      end
      PAD:      if (cnt_inc >= MIN_CNT) state_d = FCS;
      FCS:      if (fcs_idx_q == 2'd3) state_d = IFG;
      DROP:     if (valid && eof) state_d = IFG;
      IFG:      if (ifg_cnt_q == 4'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d       = 8'h00;
    txen_d      = 1'b0;
    txer_d      = 1'b0;
    crc_d       = crc_q;
    byte_cnt_d  = byte_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    fcs_idx_d   = fcs_idx_q;
    ifg_cnt_d   = ifg_cnt_q;
    err_d       = err_q;
    first_d     = first_q;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      IDLE: begin
        crc_d      = CRC32_INIT;
        byte_cnt_d = 11'd0;
        fcs_idx_d  = 2'd0;
        err_d      = 1'b0;
        first_d    = 1'b1;
        // The first preamble byte leaves while the sof byte is still held.
        if (valid && sof) begin
          txd_d     = PREAMBLE_BYTE;
          txen_d    = 1'b1;
          pre_cnt_d = PRE_LOAD;
        end
      end
      PREAMBLE: begin
        txen_d = 1'b1;
        if (pre_cnt_q == 3'd0) begin
          txd_d = SFD_BYTE;
        end else begin
          txd_d     = PREAMBLE_BYTE;
          pre_cnt_d = pre_cnt_q - 3'd1;
        end
      end
      DATA: begin
        if (data_abort) begin
          txen_d      = 1'b1;
          txer_d      = 1'b1;
          abort_cnt_d = abort_cnt_q + 32'd1;
          if (valid && eof) ifg_cnt_d = IFG_LOAD;
        end else begin
          txd_d      = tx_if.frame_data_i;
          txen_d     = 1'b1;
          crc_d      = crc32_next(crc_q, tx_if.frame_data_i);
          byte_cnt_d = cnt_inc;
          first_d    = 1'b0;
          if (eof) err_d = tx_if.frame_error_i;
        end
      end
      PAD: begin
        txen_d     = 1'b1;
        crc_d      = crc32_next(crc_q, 8'h00);
        byte_cnt_d = cnt_inc;
      end
      FCS: begin
        txen_d    = 1'b1;
        txd_d     = fcs_word[{fcs_idx_q, 3'b000} +: 8];
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          ifg_cnt_d   = IFG_LOAD;
        end
      end
      DROP: begin
        if (valid && eof) ifg_cnt_d = IFG_LOAD;
      end
      IFG: begin
        if (ifg_cnt_q != 4'd0) ifg_cnt_d = ifg_cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      pre_cnt_q   <= 3'd0;
      byte_cnt_q  <= 11'd0;
      fcs_idx_q   <= 2'd0;
      ifg_cnt_q   <= 4'd0;
      crc_q       <= CRC32_INIT;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      txd_q       <= 8'h00;
      txen_q      <= 1'b0;
      txer_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
      abort_cnt_q <= 32'd0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      fcs_idx_q   <= fcs_idx_d;
      ifg_cnt_q   <= ifg_cnt_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      first_q     <= first_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      txer_q      <= txer_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  // Ready is combinational (IDLE drain depends on the input), so it is gated
  // by reset to stay low while reset is held.
  assign tx_if.frame_ready_o    = ready_c & switch_rst_n;
  assign tx_if.gmii_tx_data_o   = txd_q;
  assign tx_if.gmii_tx_en_o     = txen_q;
  assign tx_if.gmii_tx_er_o     = txer_q;
  assign tx_if.tx_frame_count_o = frame_cnt_q;
  assign tx_if.tx_abort_count_o = abort_cnt_q;

endmodule

// File: tb/tb_tx_mac_control.sv
// Directed-sequence bench with random payloads, checked against a frame-level
// model (preamble + padded payload + bit-serial reference FCS).
module tb_tx_mac_control;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [8:0] sym_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_mac_control_if m ();
  tx_mac_control dut (.switch_clk(clk), .switch_rst_n(rst_n), .tx_if(m));

  int n_checks = 0;
  int n_errs   = 0;
  int exp_frames = 0;
  int exp_aborts = 0;

  // Monitor: captured {er,data} while tx_en, plus tx_en run and gap lengths.
  logic [8:0] cap[$];
  int runs[$];
  int gaps[$];
  int run_len = 0, gap_len = 0, er_total = 0;
  bit en_prev = 0, seen_en = 0;
  int cb, rb, gb, erb;

  always @(negedge clk) begin
    if (m.gmii_tx_en_o === 1'b1) begin
      if (!en_prev && seen_en) gaps.push_back(gap_len);
      cap.push_back({m.gmii_tx_er_o, m.gmii_tx_data_o});
      run_len++;
      gap_len = 0;
      seen_en = 1;
    end else begin
      if (en_prev) runs.push_back(run_len);
      run_len = 0;
      gap_len++;
    end
    if (m.gmii_tx_er_o === 1'b1) er_total++;
    en_prev = (m.gmii_tx_en_o === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Normal-form (MSB-first register) CRC-32 over bits in wire order.
  function automatic logic [31:0] crc_reg(input byte_q_t d);
    logic [31:0] r;
    logic fb;
    r = 32'hFFFF_FFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[31] ^ d[k][b];
        r  = {r[30:0], 1'b0};
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    end
    return r;
  endfunction

  // FCS as a 32-bit word whose byte 0 goes on the wire first.
  function automatic logic [31:0] ref_fcs(input byte_q_t d);
    logic [31:0] r, o;
    r = crc_reg(d);
    for (int b = 0; b < 32; b++) o[b] = ~r[31-b];
    return o;
  endfunction

  function automatic sym_q_t build_frame(input byte_q_t pl, input bit err);
    sym_q_t e;
    byte_q_t p;
    logic [31:0] f;
    e = {};
    for (int i = 0; i < 7; i++) e.push_back({1'b0, 8'h55});
    e.push_back({1'b0, 8'hD5});
    p = pl;
    while (p.size() < 60) p.push_back(8'h00);
    foreach (p[i]) e.push_back({1'b0, p[i]});
    f = ref_fcs(p);
    for (int i = 0; i < 4; i++) e.push_back({1'b0, f[8*i +: 8] ^ (err ? 8'hFF : 8'h00)});
    return e;
  endfunction

  function automatic byte_q_t rand_payload(input int n);
    byte_q_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  function automatic int get_run(input int idx);
    return (idx < runs.size()) ? runs[idx] : -1;
  endfunction

  task automatic mark();
    cb = cap.size(); rb = runs.size(); gb = gaps.size(); erb = er_total;
  endtask

  task automatic settle();
    repeat (80) @(posedge clk);
    #1;
  endtask

  task automatic send(input byte_q_t pl, input bit err, input int gap_at,
                      input int sof_at, input int stop_at);
    bit r;
    int t;
    for (int i = 0; i < pl.size(); i++) begin
      if (i == gap_at) begin
        m.frame_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      m.frame_data_i  = pl[i];
      m.frame_valid_i = 1'b1;
      m.frame_sof_i   = (i == 0) || (i == sof_at);
      m.frame_eof_i   = (i == pl.size() - 1);
      m.frame_error_i = err && (i == pl.size() - 1);
      t = 0;
      do begin
        @(negedge clk); r = m.frame_ready_o;
        @(posedge clk); #1; t++;
      end while (!r && t < 4000);
      if (!r) begin
        n_checks++; n_errs++;
        $error("FAIL accept_timeout byte %0d observed ready=0 expected ready=1", i);
        m.frame_valid_i = 1'b0;
        return;
      end
      if (i + 1 == stop_at) return;
    end
    m.frame_valid_i = 1'b0;
    m.frame_sof_i   = 1'b0;
    m.frame_eof_i   = 1'b0;
    m.frame_error_i = 1'b0;
  endtask

  task automatic compare_stream(input string tag, input sym_q_t e);
    int nb, first;
    logic [8:0] ob, eb;
    nb = 0; first = 0; ob = '0; eb = '0;
    for (int i = 0; i < e.size(); i++) begin
      if (cb + i >= cap.size() || cap[cb+i] !== e[i]) begin
        if (nb == 0) begin
          first = i;
          ob = (cb + i < cap.size()) ? cap[cb+i] : 9'h1FF;
          eb = e[i];
        end
        nb++;
      end
    end
    n_checks++;
    assert (nb == 0) else begin
      n_errs++;
      $error("FAIL %s stream: %0d bad symbols, first at %0d observed=%h expected=%h",
             tag, nb, first, ob, eb);
    end
  endtask

  task automatic check_frame(input string tag, input byte_q_t pl, input bit err);
    sym_q_t e;
    byte_q_t rx;
    e = build_frame(pl, err);
    chk({tag, " len"}, 64'(cap.size() - cb), 64'(e.size()));
    chk({tag, " runs"}, 64'(runs.size() - rb), 64'd1);
    chk({tag, " run_len"}, 64'(get_run(rb)), 64'(e.size()));
    chk({tag, " tx_er"}, 64'(er_total - erb), 64'd0);
    compare_stream(tag, e);
    if (!err && cap.size() - cb >= e.size()) begin
      rx = {};
      for (int i = 8; i < e.size(); i++) rx.push_back(cap[cb+i][7:0]);
      chk({tag, " rx_residue"}, 64'(crc_reg(rx)), 64'h0000_0000_C704_DD7B);
    end
  endtask

  task automatic check_abort(input string tag, input byte_q_t pl, input int k);
    sym_q_t e;
    int idx;
    e = {};
    for (int i = 0; i < 7; i++) e.push_back({1'b0, 8'h55});
    e.push_back({1'b0, 8'hD5});
    for (int i = 0; i < k; i++) e.push_back({1'b0, pl[i]});
    compare_stream(tag, e);
    idx = cb + 8 + k;
    chk({tag, " er_cycle"}, 64'((idx < cap.size()) ? cap[idx][8] : 1'b0), 64'd1);
    chk({tag, " len"}, 64'(cap.size() - cb), 64'(8 + k + 1));
    chk({tag, " runs"}, 64'(runs.size() - rb), 64'd1);
    chk({tag, " run_len"}, 64'(get_run(rb)), 64'(8 + k + 1));
    chk({tag, " tx_er"}, 64'(er_total - erb), 64'd1);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " frame_count"}, 64'(m.tx_frame_count_o), 64'(exp_frames));
    chk({tag, " abort_count"}, 64'(m.tx_abort_count_o), 64'(exp_aborts));
  endtask

  initial begin
    byte_q_t p64, p14, p100, p30, pa, pb, pl, pn;
    sym_q_t e2;
    int len;
    bit err;

    m.frame_data_i = 8'h00; m.frame_valid_i = 1'b0; m.frame_sof_i = 1'b0;
    m.frame_eof_i = 1'b0;   m.frame_error_i = 1'b0;
    #12;
    m.frame_valid_i = 1'b1; m.frame_data_i = 8'hAA;
    #1;
    chk("rst tx_en", 64'(m.gmii_tx_en_o), 64'd0);
    chk("rst tx_er", 64'(m.gmii_tx_er_o), 64'd0);
    chk("rst tx_data", 64'(m.gmii_tx_data_o), 64'd0);
    chk("rst ready", 64'(m.frame_ready_o), 64'd0);
    chk_counts("rst");
    m.frame_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    p64 = rand_payload(64);
    mark(); send(p64, 1'b0, -1, -1, -1); settle();
    check_frame("f64", p64, 1'b0); exp_frames++; chk_counts("f64");

    p14 = rand_payload(14);
    mark(); send(p14, 1'b0, -1, -1, -1); settle();
    check_frame("f14", p14, 1'b0); exp_frames++; chk_counts("f14");

    mark(); send(p64, 1'b1, -1, -1, -1); settle();
    check_frame("f64err", p64, 1'b1); exp_frames++; chk_counts("f64err");

    mark();
    m.frame_data_i = 8'h3C; m.frame_valid_i = 1'b1; m.frame_sof_i = 1'b0;
    @(negedge clk); chk("idle_drain ready", 64'(m.frame_ready_o), 64'd1);
    @(posedge clk); #1; m.frame_valid_i = 1'b0;
    settle();
    chk("idle_drain no_tx", 64'(cap.size() - cb), 64'd0);

    p100 = rand_payload(100);
    mark(); send(p100, 1'b0, 20, -1, -1); settle();
    check_abort("underrun", p100, 20); exp_aborts++; chk_counts("underrun");

    p30 = rand_payload(30);
    mark(); send(p30, 1'b0, -1, 10, -1); settle();
    check_abort("sof_mid", p30, 10); exp_aborts++; chk_counts("sof_mid");

    pa = rand_payload(64); pb = rand_payload(64);
    mark(); send(pa, 1'b0, -1, -1, -1); send(pb, 1'b0, -1, -1, -1); settle();
    e2 = build_frame(pa, 1'b0);
    e2 = {e2, build_frame(pb, 1'b0)};
    compare_stream("b2b", e2);
    chk("b2b gap", 64'((gb + 1 < gaps.size()) ? gaps[gb+1] : -1), 64'd12);
    chk("b2b run0", 64'(get_run(rb)), 64'd76);
    chk("b2b run1", 64'(get_run(rb + 1)), 64'd76);
    exp_frames += 2; chk_counts("b2b");

    foreach (p64[i]) begin end
    pl = rand_payload(59);
    mark(); send(pl, 1'b0, -1, -1, -1); settle();
    check_frame("f59", pl, 1'b0); exp_frames++;
    pl = rand_payload(60);
    mark(); send(pl, 1'b0, -1, -1, -1); settle();
    check_frame("f60", pl, 1'b0); exp_frames++;
    pl = rand_payload(1514);
    mark(); send(pl, 1'b0, -1, -1, -1); settle();
    check_frame("f1514", pl, 1'b0); exp_frames++; chk_counts("f1514");

    pl = rand_payload(1515);
    mark(); send(pl, 1'b0, -1, -1, -1); settle();
    check_abort("oversize", pl, 1514); exp_aborts++; chk_counts("oversize");

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 130);
      err = 1'($urandom_range(0, 1));
      pl  = rand_payload(len);
      mark(); send(pl, err, -1, -1, -1); settle();
      check_frame($sformatf("rnd%0d_len%0d", r, len), pl, err);
      exp_frames++;
    end
    chk_counts("rnd");

    pl = rand_payload(100);
    send(pl, 1'b0, -1, -1, 30);
    #2; rst_n = 1'b0; #1;
    chk("arst tx_en", 64'(m.gmii_tx_en_o), 64'd0);
    chk("arst tx_er", 64'(m.gmii_tx_er_o), 64'd0);
    chk("arst tx_data", 64'(m.gmii_tx_data_o), 64'd0);
    chk("arst ready", 64'(m.frame_ready_o), 64'd0);
    exp_frames = 0; exp_aborts = 0;
    chk_counts("arst");
    m.frame_valid_i = 1'b0; m.frame_sof_i = 1'b0; m.frame_eof_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    pn = rand_payload(40);
    mark();
    @(posedge clk); #1;
    m.frame_data_i = pn[0]; m.frame_valid_i = 1'b1; m.frame_sof_i = 1'b1;
    m.frame_eof_i = 1'b0;   m.frame_error_i = 1'b0;
    @(negedge clk); chk("post_rst T tx_en", 64'(m.gmii_tx_en_o), 64'd0);
    @(negedge clk);
    chk("post_rst T+1 tx_en", 64'(m.gmii_tx_en_o), 64'd1);
    chk("post_rst T+1 data", 64'(m.gmii_tx_data_o), 64'h55);
    send(pn, 1'b0, -1, -1, -1); settle();
    check_frame("post_rst", pn, 1'b0); exp_frames++; chk_counts("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
